uart_rx_frame: RTL

//   Serial receiver paired with the command transmitter; it is the line-side consumer of its frames.

---
 rtl/uart_rx_frame.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Line-side receiver for command-transmitter frames.
//   Frame format, LSB first: start(0), DATA_WIDTH data bits, optional odd-parity bit, stop(1).
//   The asynchronous rx line goes through a 2-flop synchroniser. Each bit is sampled at mid-bit.
//   A received byte is presented on a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous, idles high
//   rx_data    out  received byte, valid while rx_vld = 1
//   rx_vld     out  byte available
//   rx_rdy     in   consumer accepts; a transfer happens when rx_vld & rx_rdy
//   parity_err out  1-cycle pulse: parity mismatch (CHECK = 1 only)
//   frame_err  out  1-cycle pulse: stop bit sampled 0
//   overrun    out  1-cycle pulse: frame completed while the previous byte was still pending
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BR         = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int CHECK      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_vld,
  input  logic                  rx_rdy,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BR_DIV = CLK_FREQ / BR;
  localparam int CW     = $clog2(BR_DIV);
  localparam int BW     = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(BR_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BR_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                  state;
  logic                    rx_meta;
  logic                    rx_s;
  logic                    rx_s_prev;
  logic [CW-1:0]           baud_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    perr_q;
  logic                    deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_prev  <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      perr_q     <= 1'b0;
      deliver    <= 1'b0;
      rx_data    <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_s_prev <= rx_s;

      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      deliver    <= 1'b0;

      if (rx_vld && rx_rdy)
        rx_vld <= 1'b0;

      // Delivery runs one cycle after the stop sample. The assignments here come after
      // the handshake clear, so a delivery in the same cycle takes precedence over it.
      if (deliver) begin
        if (!rx_vld || rx_rdy) begin
          rx_data <= shift;
          rx_vld  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
        parity_err <= perr_q;
      end

      case (state)
        IDLE: begin
          if (rx_s_prev && !rx_s) begin
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == HALF_CNT) begin
            if (rx_s) begin
              state <= IDLE;                  // glitch, not a real start bit
            end else begin
              baud_cnt <= '0;
              bit_cnt  <= '0;
              perr_q   <= 1'b0;
              state    <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT)
              state <= (CHECK != 0) ? PARITY : STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            perr_q   <= ~(^shift ^ rx_s);        // odd parity: total ones must be odd
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            if (rx_s) begin
              deliver <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must produce only one frame_err, so wait here for the line to go high.
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
